// File: rtl/regfile_write_bank_pkg.sv
// Shared sizing constants for the 16-entry write-back register bank.
package regfile_write_bank_pkg;
    localparam int unsigned REG_COUNT = 16;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned DEF_WIDTH = 4;
    localparam logic [DEF_WIDTH-1:0] DEF_RESET_VAL = '0;
endpackage

// File: rtl/regfile_write_bank_if.sv
// Write-back request bus from execute plus the in-flight write exposed for bypass.
interface regfile_write_bank_if
    import regfile_write_bank_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic              clr;
    logic              fwd_valid;
    logic [ADDR_W-1:0] fwd_addr;
    logic [WIDTH-1:0]  fwd_data;

    modport master (
        output we, waddr, wdata, clr,
        input  fwd_valid, fwd_addr, fwd_data
    );

    modport slave (
        input  we, waddr, wdata, clr,
        output fwd_valid, fwd_addr, fwd_data
    );
endinterface

// File: rtl/regfile_write_bank_dec4to16.sv
// One-hot decode of the pending write address into per-register write enables.
module regfile_write_bank_dec4to16
    import regfile_write_bank_pkg::*;
(
    input  logic                 en,
    input  logic [ADDR_W-1:0]    addr,
    output logic [REG_COUNT-1:0] onehot
);
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end
endmodule

// File: rtl/regfile_write_bank.sv
// Write side of the 16 x WIDTH register file: one-cycle pending stage, then commit.
module regfile_write_bank
    import regfile_write_bank_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
    input  logic               clk,
    input  logic               n_reset,
    regfile_write_bank_if.slave bus,
    output logic [WIDTH-1:0]   q0,
    output logic [WIDTH-1:0]   q1,
    output logic [WIDTH-1:0]   q2,
    output logic [WIDTH-1:0]   q3,
    output logic [WIDTH-1:0]   q4,
    output logic [WIDTH-1:0]   q5,
    output logic [WIDTH-1:0]   q6,
    output logic [WIDTH-1:0]   q7,
    output logic [WIDTH-1:0]   q8,
    output logic [WIDTH-1:0]   q9,
    output logic [WIDTH-1:0]   qa,
    output logic [WIDTH-1:0]   qb,
    output logic [WIDTH-1:0]   qc,
    output logic [WIDTH-1:0]   qd,
    output logic [WIDTH-1:0]   qe,
    output logic [WIDTH-1:0]   qf
);
    logic                 pend_v;
    logic [ADDR_W-1:0]    pend_a;
    logic [WIDTH-1:0]     pend_d;
    logic [REG_COUNT-1:0] wen;
    logic [WIDTH-1:0]     regs [REG_COUNT];

    // Address/data track the bus every cycle; only the valid bit is gated by clr.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            pend_v <= 1'b0;
            pend_a <= '0;
            pend_d <= '0;
        end else begin
            pend_v <= bus.we & ~bus.clr;
            pend_a <= bus.waddr;
            pend_d <= bus.wdata;
        end
    end

    regfile_write_bank_dec4to16 u_dec (
        .en     (pend_v),
        .addr   (pend_a),
        .onehot (wen)
    );

    // clr outranks the pending commit, so a write latched before clr is lost.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) regs[i] <= RESET_VAL;
        end else if (bus.clr) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) regs[i] <= RESET_VAL;
        end else begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                if (wen[i]) regs[i] <= pend_d;
            end
        end
    end

    assign bus.fwd_valid = pend_v;
    assign bus.fwd_addr  = pend_a;
    assign bus.fwd_data  = pend_d;

    assign q0 = regs[0];
    assign q1 = regs[1];
    assign q2 = regs[2];
    assign q3 = regs[3];
    assign q4 = regs[4];
    assign q5 = regs[5];
    assign q6 = regs[6];
    assign q7 = regs[7];
    assign q8 = regs[8];
    assign q9 = regs[9];
    assign qa = regs[10];
    assign qb = regs[11];
    assign qc = regs[12];
    assign qd = regs[13];
    assign qe = regs[14];
    assign qf = regs[15];
endmodule

// File: tb/tb_regfile_write_bank.sv
// Scoreboard bench for regfile_write_bank: stimulus pushes per-edge expectations, monitor compares.
module tb_regfile_write_bank;
    logic clk = 1'b0;
    logic n_reset;
    logic [3:0] q0, q1, q2, q3, q4, q5, q6, q7, q8, q9, qa, qb, qc, qd, qe, qf;

    regfile_write_bank_if #(.WIDTH(4)) bus ();

    regfile_write_bank #(.WIDTH(4), .RESET_VAL(4'h0)) dut (
        .clk(clk), .n_reset(n_reset), .bus(bus),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5), .q6(q6), .q7(q7),
        .q8(q8), .q9(q9), .qa(qa), .qb(qb), .qc(qc), .qd(qd), .qe(qe), .qf(qf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic [3:0]  fa;
        logic [3:0]  fd;
        logic [63:0] qv;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    logic [3:0] m_regs [16];
    logic       m_pv;
    logic [3:0] m_pa;
    logic [3:0] m_pd;

    function automatic logic [63:0] get_q();
        return {qf, qe, qd, qc, qb, qa, q9, q8, q7, q6, q5, q4, q3, q2, q1, q0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check_q(input string name, input int idx, input logic [3:0] req);
        logic [63:0] qv;
        qv = get_q();
        check(name, 64'(qv[idx*4 +: 4]), 64'(req));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 4'h0;
        m_pv = 1'b0;
        m_pa = 4'h0;
        m_pd = 4'h0;
    endtask

    // Expected state after the next rising edge, given the inputs just driven.
    task automatic model_edge(input logic w, input logic [3:0] a, input logic [3:0] d, input logic c);
        exp_t e;
        if (c) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 4'h0;
        end else if (m_pv) begin
            m_regs[m_pa] = m_pd;
        end
        m_pv = w & ~c;
        m_pa = a;
        m_pd = d;
        e.fv = m_pv;
        e.fa = m_pa;
        e.fd = m_pd;
        for (int i = 0; i < 16; i++) e.qv[i*4 +: 4] = m_regs[i];
        sb.push_back(e);
    endtask

    task automatic step(input logic w, input logic [3:0] a, input logic [3:0] d, input logic c);
        @(negedge clk);
        #2;
        bus.we = w;
        bus.waddr = a;
        bus.wdata = d;
        bus.clr = c;
        model_edge(w, a, d, c);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #1;
        check("pre_reset_fwd_valid", 64'(bus.fwd_valid), 64'(1));
        n_reset = 1'b0;
        bus.we = 1'b0;
        bus.waddr = 4'h0;
        bus.wdata = 4'h0;
        bus.clr = 1'b0;
        #1;
        check("async_reset_q", get_q(), 64'h0);
        check("async_reset_fwd", {bus.fwd_valid, bus.fwd_addr, bus.fwd_data}, 64'h0);
        model_reset();
        #1;
        n_reset = 1'b1;
        model_edge(1'b0, 4'h0, 4'h0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_fwd_valid", 64'(bus.fwd_valid), 64'(e.fv));
                check("sb_fwd_addr", 64'(bus.fwd_addr), 64'(e.fa));
                check("sb_fwd_data", 64'(bus.fwd_data), 64'(e.fd));
                check("sb_q", get_q(), e.qv);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        n_reset = 1'b0;
        bus.we = 1'b0;
        bus.waddr = 4'h0;
        bus.wdata = 4'h0;
        bus.clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_q", get_q(), 64'h0);
        check("reset_fwd", {bus.fwd_valid, bus.fwd_addr, bus.fwd_data}, 64'h0);
        #1;
        n_reset = 1'b1;

        // Single write: 5 <= A
        step(1'b1, 4'h5, 4'hA, 1'b0);
        step(1'b0, 4'h0, 4'h0, 1'b0);
        check("single_fwd", {bus.fwd_valid, bus.fwd_addr, bus.fwd_data}, 64'h15A);
        check_q("single_q5_before_commit", 5, 4'h0);
        step(1'b0, 4'h0, 4'h0, 1'b0);
        check_q("single_q5", 5, 4'hA);
        check("single_others", get_q(), 64'h0000_0000_00A0_0000);

        // Streaming: reg i <= 15-i
        for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 4'(15 - i), 1'b0);
        step(1'b0, 4'h0, 4'h0, 1'b0);
        check("stream_fwd_last", {bus.fwd_valid, bus.fwd_addr, bus.fwd_data}, 64'h1F0);
        step(1'b0, 4'h0, 4'h0, 1'b0);
        check("stream_fwd_drop", 64'(bus.fwd_valid), 64'(0));
        check("stream_all", get_q(), 64'h0123_4567_89AB_CDEF);

        // Same address back to back
        step(1'b1, 4'h3, 4'h1, 1'b0);
        step(1'b1, 4'h3, 4'h7, 1'b0);
        step(1'b0, 4'h0, 4'h0, 1'b0);
        check_q("same_addr_first", 3, 4'h1);
        step(1'b0, 4'h0, 4'h0, 1'b0);
        check_q("same_addr_second", 3, 4'h7);

        // Clear priority over pending write and concurrent request
        step(1'b1, 4'h9, 4'hC, 1'b0);
        step(1'b1, 4'h2, 4'hE, 1'b1);
        step(1'b0, 4'h0, 4'h0, 1'b0);
        check("clr_all_q", get_q(), 64'h0);
        check("clr_fwd_valid", 64'(bus.fwd_valid), 64'(0));
        step(1'b0, 4'h0, 4'h0, 1'b0);
        check_q("clr_q9", 9, 4'h0);
        check_q("clr_q2", 2, 4'h0);

        // Reset mid-flight: populate, then write 4 <= 6 and reset before commit
        step(1'b1, 4'hB, 4'h5, 1'b0);
        step(1'b1, 4'h4, 4'h6, 1'b0);
        reset_pulse();
        step(1'b0, 4'h0, 4'h0, 1'b0);
        check_q("midreset_q4", 4, 4'h0);
        check_q("midreset_qb", 11, 4'h0);
        step(1'b1, 4'h1, 4'h3, 1'b0);
        step(1'b0, 4'h0, 4'h0, 1'b0);
        step(1'b0, 4'h0, 4'h0, 1'b0);
        check_q("post_reset_write", 1, 4'h3);

        @(negedge clk);
        #1;
        check("sb_drain", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
